// File: rtl/seg_pkg.sv
// Shared definitions for the 6-digit seven-segment display path.
package seg_pkg;

  localparam int unsigned DIGITS_DEF = 6;
  localparam int unsigned BCD_MAX    = 999_999;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StFin
  } conv_state_e;

  // Blank mask for an all-zero value: every digit blank except digit 0.
  function automatic logic [31:0] blank_rst_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 1; i < n && i < 32; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int unsigned BinW   = 20,
  parameter int unsigned Digits = 6
) ();

  logic                  start;
  logic [BinW-1:0]       bin;
  logic                  busy;
  logic                  done;
  logic [4*Digits-1:0]   bcd;
  logic [Digits-1:0]     blank;
  logic                  ovf;

  // Requester side.
  modport master (
    output start, bin,
    input  busy, done, bcd, blank, ovf
  );

  // Converter side.
  modport slave (
    input  start, bin,
    output busy, done, bcd, blank, ovf
  );

endinterface

// File: rtl/bcd_dig_adj.sv
// Shift-add-3 digit correction: a digit >= 5 gets +3 so the next shift carries correctly.
module bcd_dig_adj
  import seg_pkg::*;
(
  input  bcd_digit_t dig_i,
  output bcd_digit_t dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one shift per input bit.
// Results (bcd, blank, ovf) update only when a conversion finishes.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BinW   = 20,
  parameter int unsigned Digits = DIGITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2bcd_seq_if.slave bus_io
);

  localparam int unsigned     CntW     = (BinW > 1) ? $clog2(BinW) : 1;
  localparam int unsigned     ScrD     = Digits + 1;  // extra digit holds 2^BinW overflow range
  localparam int unsigned     ScrW     = 4 * ScrD;
  localparam int unsigned     BcdW     = 4 * Digits;
  localparam longint unsigned MaxVal   = pow10(Digits) - 1;
  localparam logic [Digits-1:0] BlankRst = Digits'(blank_rst_mask(Digits));

  conv_state_e         state_q;
  logic [CntW-1:0]     cnt_q;
  logic [BinW-1:0]     shift_q;
  logic [ScrW-1:0]     scr_q;
  logic                ovf_pend_q;
  logic                busy_q;
  logic                done_q;
  logic [BcdW-1:0]     bcd_q;
  logic [Digits-1:0]   blank_q;
  logic                ovf_q;

  logic [ScrW-1:0]     scr_adj;
  logic [ScrW-1:0]     scr_d;
  logic [BinW-1:0]     shift_d;
  logic [BcdW-1:0]     res_bcd;
  logic [Digits-1:0]   res_blank;
  logic                ovf_in;
  logic                zero_run;

  for (genvar g = 0; g < ScrD; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .dig_i (scr_q[4*g +: 4]),
      .dig_o (scr_adj[4*g +: 4])
    );
  end

  assign ovf_in = (64'(bus_io.bin) > MaxVal);

  // One conversion step and the formatted result taken from the post-shift scratch.
  always_comb begin
    {scr_d, shift_d} = {scr_adj, shift_q} << 1;
    res_bcd          = ovf_pend_q ? {Digits{4'h9}} : scr_d[BcdW-1:0];
    res_blank        = '0;
    zero_run         = 1'b1;
    for (int i = Digits - 1; i >= 1; i--) begin
      zero_run     = zero_run && (res_bcd[4*i +: 4] == 4'h0);
      res_blank[i] = zero_run;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      scr_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BlankRst;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          if (bus_io.start) begin
            shift_q    <= bus_io.bin;
            scr_q      <= '0;
            cnt_q      <= CntW'(BinW - 1);
            ovf_pend_q <= ovf_in;
            busy_q     <= 1'b1;
            state_q    <= StConv;
          end else begin
            state_q <= StIdle;
          end
        end
        StConv: begin
          scr_q   <= scr_d;
          shift_q <= shift_d;
          if (cnt_q == '0) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= res_bcd;
            blank_q <= res_blank;
            ovf_q   <= ovf_pend_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy  = busy_q;
  assign bus_io.done  = done_q;
  assign bus_io.bcd   = bcd_q;
  assign bus_io.blank = blank_q;
  assign bus_io.ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and table-driven bench for bin2bcd_seq.
module tb_bin2bcd_seq;
  import seg_pkg::*;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bin2bcd_seq_if #(.BinW(20), .Digits(6)) bus ();

  bin2bcd_seq #(.BinW(20), .Digits(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_bcd(input logic [19:0] b);
    logic [23:0] r;
    int unsigned v;
    if (b > 20'(BCD_MAX)) return 24'h999999;
    v = b;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_blank(input logic [23:0] d);
    logic [5:0] bl;
    logic       z;
    bl = '0;
    z  = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      z     = z && (d[4*i +: 4] == 4'h0);
      bl[i] = z;
    end
    return bl;
  endfunction

  // Full conversion from IDLE: timing, result and single-cycle done.
  task automatic run_and_check(input string tag, input logic [19:0] b, input logic [23:0] eb,
                               input logic [5:0] ebl, input logic eo);
    int   busy_cnt;
    int   done_at;
    logic got;
    bus.bin   = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = ~b;
    busy_cnt  = 0;
    done_at   = 0;
    got       = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        got     = 1'b1;
        done_at = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd20);
    check({tag, " done_edge"}, 32'(done_at), 32'd21);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " bcd"}, 32'(bus.bcd), 32'(eb));
    check({tag, " blank"}, 32'(bus.blank), 32'(ebl));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t        vecs [13];
    int          ndone;
    int          gap;
    logic [19:0] b;
    logic [23:0] eb;

    vecs[0]  = '{20'd123456,  24'h123456, 6'b000000, 1'b0};
    vecs[1]  = '{20'd0,       24'h000000, 6'b111110, 1'b0};
    vecs[2]  = '{20'd42,      24'h000042, 6'b111100, 1'b0};
    vecs[3]  = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
    vecs[4]  = '{20'd1000000, 24'h999999, 6'b000000, 1'b1};
    vecs[5]  = '{20'hFFFFF,   24'h999999, 6'b000000, 1'b1};
    vecs[6]  = '{20'd7,       24'h000007, 6'b111110, 1'b0};
    vecs[7]  = '{20'd100000,  24'h100000, 6'b000000, 1'b0};
    vecs[8]  = '{20'd10,      24'h000010, 6'b111100, 1'b0};
    vecs[9]  = '{20'd99999,   24'h099999, 6'b100000, 1'b0};
    vecs[10] = '{20'd1000,    24'h001000, 6'b110000, 1'b0};
    vecs[11] = '{20'd65535,   24'h065535, 6'b100000, 1'b0};
    vecs[12] = '{20'd1,       24'h000001, 6'b111110, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    #23;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset bcd", 32'(bus.bcd), 32'h0);
    check("reset blank", 32'(bus.blank), 32'b111110);
    check("reset ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].blank, vecs[i].ovf);
    end

    // Start during CONV is ignored.
    bus.bin   = 20'd123;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.bin   = 20'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        ndone++;
        if (ndone == 1) check("ignore_start bcd", 32'(bus.bcd), 32'h000123);
      end
      @(posedge clk); #1;
    end
    check("ignore_start done_count", 32'(ndone), 32'd1);

    // Back-to-back via start held through FIN.
    bus.bin   = 20'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.bin = 20'd6;
    ndone   = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    check("b2b first done", 32'(bus.done), 32'd1);
    check("b2b first bcd", 32'(bus.bcd), 32'h000005);
    gap = 0;
    @(posedge clk); #1;
    gap++;
    bus.start = 1'b0;
    check("b2b recaptured busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(posedge clk); #1;
      gap++;
      if (gap == 10) check("b2b bcd held", 32'(bus.bcd), 32'h000005);
    end
    check("b2b done gap", 32'(gap), 32'd21);
    check("b2b second bcd", 32'(bus.bcd), 32'h000006);
    check("b2b second blank", 32'(bus.blank), 32'b111110);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a conversion.
    bus.bin   = 20'd123456;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort bcd", 32'(bus.bcd), 32'h0);
    check("abort blank", 32'(bus.blank), 32'b111110);
    check("abort ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    run_and_check("after_abort", 20'd42, 24'h000042, 6'b111100, 1'b0);

    // Sweep against the decimal reference model.
    for (int i = 0; i < 200; i++) begin
      if (i == 0) b = 20'd999999;
      else if (i == 1) b = 20'd1000000;
      else if (i % 2 == 0) b = 20'($urandom_range(0, 999999));
      else b = 20'($urandom_range(0, 20'hFFFFF));
      eb = ref_bcd(b);
      run_and_check($sformatf("sweep%0d bin=%0d", i, b), b, eb, ref_blank(eb),
                    b > 20'(BCD_MAX));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
